// File: rtl/ts_pkg.sv
// Shared constants and state encoding for the s-curve threshold sweeper.
// Command codes are the scan block's CMD byte values.
package ts_pkg;

  localparam logic [7:0] CMD_ARM  = 8'h99;
  localparam logic [7:0] CMD_RUN  = 8'h19;
  localparam logic [7:0] CMD_IDLE = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    ARM,
    RUN,
    CAPTURE,
    EVAL,
    NEXT,
    FINISH
  } state_t;

endpackage

// File: rtl/ts_sweep_eval.sv
// Per-point s-curve evaluator: tracks the first threshold
// crossing of Target and the peak accumulator value.
module ts_sweep_eval #(
  parameter int DAC_W = 10,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             eval,
  input  logic             first,
  input  logic [ACC_W-1:0] acc_lat,
  input  logic [ACC_W-1:0] target,
  input  logic [DAC_W-1:0] dac,
  output logic             found,
  output logic [DAC_W-1:0] thr50,
  output logic [ACC_W-1:0] acc_at_thr,
  output logic [ACC_W-1:0] acc_max
);

  logic prev_cmp;
  logic cmp;

  assign cmp = (acc_lat >= target);

  // Result registers; the first point only seeds prev_cmp.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      prev_cmp   <= 1'b0;
      found      <= 1'b0;
      thr50      <= '0;
      acc_at_thr <= '0;
      acc_max    <= '0;
    end else if (eval) begin
      prev_cmp <= cmp;
      if (acc_lat > acc_max)
        acc_max <= acc_lat;
      if (!first && (cmp != prev_cmp) && !found) begin
        found      <= 1'b1;
        thr50      <= dac;
        acc_at_thr <= acc_lat;
      end
    end
  end

endmodule

// File: rtl/ts_scurve_sweep.sv
// Threshold sweep sequencer for the s-curve scan block.
// TS_SWEEP_TIMEOUT_EN adds a per-point ARM+RUN watchdog.
module ts_scurve_sweep #(
  parameter int DAC_W       = 10,
  parameter int ACC_W       = 12,
  parameter int SETTLE_CYC  = 16,
  parameter int ARM_CYC     = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [DAC_W-1:0] DacStart,
  input  logic [DAC_W-1:0] DacStop,
  input  logic [DAC_W-1:0] DacStep,
  input  logic [ACC_W-1:0] Target,
  input  logic [ACC_W-1:0] Acc,
  input  logic             ScanBusy,
  output logic [7:0]       CMD,
  output logic [DAC_W-1:0] DAC,
  output logic             Busy,
  output logic             Done,
  output logic             Found,
  output logic [DAC_W-1:0] Thr50,
  output logic [ACC_W-1:0] AccAtThr,
  output logic [ACC_W-1:0] AccMax,
  output logic             Err
);

  import ts_pkg::*;

  state_t           state_q, state_d;
  logic [15:0]      cnt_q;
  logic [DAC_W-1:0] dac_q;
  logic [ACC_W-1:0] acc_lat_q;
  logic             sb_q;
  logic             err_q;
  logic             first_q;
  logic [DAC_W-1:0] step;
  logic [DAC_W:0]   nxt;
  logic             last_pt;
  logic             settle_end;
  logic             arm_end;
  logic             go;
  logic             err_set;
  logic             wd_hit;

  assign go         = (state_q == IDLE) && Start;
  assign step       = (DacStep == '0) ? DAC_W'(1) : DacStep;
  assign nxt        = {1'b0, dac_q} + {1'b0, step};
  assign last_pt    = nxt[DAC_W]
                   || (nxt[DAC_W-1:0] > DacStop)
                   || (DacStop < DacStart);
  assign settle_end = (cnt_q == 16'(SETTLE_CYC - 1));
  assign arm_end    = (cnt_q == 16'(ARM_CYC - 1));

`ifdef TS_SWEEP_TIMEOUT_EN
  logic [15:0] wdog_q;
  logic        in_scan;

  assign in_scan = (state_q == ARM) || (state_q == RUN);
  assign wd_hit  = in_scan && (wdog_q == 16'(TIMEOUT_CYC - 1));

  // Watchdog spans ARM and RUN of one point, cleared elsewhere.
  always_ff @(posedge CLK) begin
    if (RST || !in_scan)
      wdog_q <= '0;
    else
      wdog_q <= wdog_q + 16'd1;
  end
`else
  assign wd_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (RST)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    CMD     = CMD_RUN;
    Busy    = 1'b1;
    Done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        CMD  = CMD_IDLE;
        Busy = 1'b0;
        if (Start)
          state_d = SETTLE;
      end
      SETTLE: begin
        if (settle_end)
          state_d = ARM;
      end
      ARM: begin
        CMD = CMD_ARM;
        if (wd_hit) begin
          err_set = 1'b1;
          state_d = FINISH;
        end else if (arm_end) begin
          if (sb_q) begin
            state_d = RUN;
          end else begin
            err_set = 1'b1;
            state_d = FINISH;
          end
        end
      end
      RUN: begin
        if (wd_hit) begin
          err_set = 1'b1;
          state_d = FINISH;
        end else if (!sb_q) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: state_d = EVAL;
      EVAL:    state_d = NEXT;
      NEXT:    state_d = last_pt ? FINISH : SETTLE;
      FINISH: begin
        CMD     = CMD_IDLE;
        Busy    = 1'b0;
        Done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: phase counter, DAC code, Acc latch, sticky error.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q     <= '0;
      dac_q     <= '0;
      acc_lat_q <= '0;
      sb_q      <= 1'b0;
      err_q     <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      sb_q  <= ScanBusy;
      cnt_q <= (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
      if (go) begin
        dac_q   <= DacStart;
        err_q   <= 1'b0;
        first_q <= 1'b1;
      end
      if (err_set)
        err_q <= 1'b1;
      if (state_q == CAPTURE)
        acc_lat_q <= Acc;
      if (state_q == EVAL)
        first_q <= 1'b0;
      if ((state_q == NEXT) && !last_pt)
        dac_q <= nxt[DAC_W-1:0];
    end
  end

  assign DAC = dac_q;
  assign Err = err_q;

  ts_sweep_eval #(
    .DAC_W (DAC_W),
    .ACC_W (ACC_W)
  ) u_eval (
    .clk        (CLK),
    .rst        (RST),
    .clr        (go),
    .eval       (state_q == EVAL),
    .first      (first_q),
    .acc_lat    (acc_lat_q),
    .target     (Target),
    .dac        (dac_q),
    .found      (Found),
    .thr50      (Thr50),
    .acc_at_thr (AccAtThr),
    .acc_max    (AccMax)
  );

endmodule

// File: tb/tb_ts_scurve_sweep.sv
// Directed bench for ts_scurve_sweep with a behavioural scan block.
// Define TS_SWEEP_TIMEOUT_EN to also exercise the watchdog.
module tb_ts_scurve_sweep;

  localparam int DW = 10;
  localparam int AW = 13;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          Start = 1'b0;
  logic [DW-1:0] DacStart = '0;
  logic [DW-1:0] DacStop = '0;
  logic [DW-1:0] DacStep = '0;
  logic [AW-1:0] Target = '0;
  logic [AW-1:0] Acc = '0;
  logic          ScanBusy = 1'b0;
  logic [7:0]    CMD;
  logic [DW-1:0] DAC;
  logic          Busy, Done, Found, Err;
  logic [DW-1:0] Thr50;
  logic [AW-1:0] AccAtThr, AccMax;

  int n_cmp = 0;
  int n_bad = 0;

  int arms = 0;
  int dones = 0;
  logic [DW-1:0] pts[$];
  bit mode_noscan = 0;
  bit mode_stuck = 0;
  int win_len = 5;
  int win = 0;
  logic prev_arm = 1'b0;
  logic [DW-1:0] acc_thr = '0;
  logic [AW-1:0] a_le = '0;
  logic [AW-1:0] a_gt = '0;
  int n;

  ts_scurve_sweep #(
    .DAC_W       (DW),
    .ACC_W       (AW),
    .SETTLE_CYC  (16),
    .ARM_CYC     (4),
    .TIMEOUT_CYC (100)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .Start    (Start),
    .DacStart (DacStart),
    .DacStop  (DacStop),
    .DacStep  (DacStep),
    .Target   (Target),
    .Acc      (Acc),
    .ScanBusy (ScanBusy),
    .CMD      (CMD),
    .DAC      (DAC),
    .Busy     (Busy),
    .Done     (Done),
    .Found    (Found),
    .Thr50    (Thr50),
    .AccAtThr (AccAtThr),
    .AccMax   (AccMax),
    .Err      (Err)
  );

  always #5 CLK = ~CLK;

  // Scan block model: busy after ARM, fixed window in RUN, Acc by DAC.
  always @(negedge CLK) begin
    if (Done) dones++;
    if (CMD == 8'h99) begin
      if (!prev_arm) begin
        arms++;
        pts.push_back(DAC);
      end
      if (!mode_noscan) ScanBusy = 1'b1;
      win = win_len;
    end else if (CMD == 8'h00) begin
      ScanBusy = 1'b0;
    end else if (ScanBusy && !mode_stuck) begin
      if (win == 0) begin
        ScanBusy = 1'b0;
        Acc = (DAC <= acc_thr) ? a_le : a_gt;
      end else begin
        win--;
      end
    end
    prev_arm = (CMD == 8'h99);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sweep(input logic [DW-1:0] s, input logic [DW-1:0] e,
                       input logic [DW-1:0] st, input int poke,
                       output int cyc);
    int d0;
    DacStart = s;
    DacStop  = e;
    DacStep  = st;
    arms = 0;
    pts.delete();
    d0 = dones;
    @(negedge CLK);
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    chk("busy_go", Busy, 1);
    chk("cmd_settle", CMD, 8'h19);
    chk("dac_first", DAC, s);
    cyc = 0;
    while (!Done && cyc < 3000) begin
      Start = (cyc == poke);
      @(negedge CLK);
      cyc++;
    end
    Start = 1'b0;
    chk("done_seen", Done, 1);
    chk("busy_at_done", Busy, 0);
    @(negedge CLK);
    chk("cmd_idle", CMD, 8'h00);
    chk("one_done", dones - d0, 1);
  endtask

  initial begin
    Target = 13'd2048;
    repeat (3) @(negedge CLK);
    chk("rst_cmd", CMD, 0);
    chk("rst_dac", DAC, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_found", Found, 0);
    chk("rst_thr", Thr50, 0);
    chk("rst_accthr", AccAtThr, 0);
    chk("rst_accmax", AccMax, 0);
    chk("rst_err", Err, 0);
    RST = 1'b0;

    // Falling s-curve 0..7, stray Start mid-sweep must be ignored.
    acc_thr = 10'd3; a_le = 13'd4096; a_gt = 13'd0;
    sweep(10'd0, 10'd7, 10'd1, 50, n);
    chk("t1_arms", arms, 8);
    chk("t1_pt0", pts[0], 0);
    chk("t1_pt7", pts[7], 7);
    chk("t1_found", Found, 1);
    chk("t1_thr", Thr50, 4);
    chk("t1_accthr", AccAtThr, 0);
    chk("t1_accmax", AccMax, 4096);
    chk("t1_err", Err, 0);

    // Stop below start: single point at DacStart.
    acc_thr = 10'd1023; a_le = 13'd100;
    sweep(10'd10, 10'd5, 10'd1, -1, n);
    chk("t2_arms", arms, 1);
    chk("t2_pt0", pts[0], 10);
    chk("t2_found", Found, 0);
    chk("t2_accmax", AccMax, 100);

    // Step 0 acts as 1, rising s-curve near the top code.
    acc_thr = 10'd1021; a_le = 13'd300; a_gt = 13'd3000;
    sweep(10'd1020, 10'd1023, 10'd0, -1, n);
    chk("t3_arms", arms, 4);
    chk("t3_pt3", pts[3], 1023);
    chk("t3_dac", DAC, 1023);
    chk("t3_found", Found, 1);
    chk("t3_thr", Thr50, 1022);
    chk("t3_accthr", AccAtThr, 3000);
    chk("t3_accmax", AccMax, 3000);

    // Step 4 from 1020 wraps past the top: carry ends the sweep.
    sweep(10'd1020, 10'd1023, 10'd4, -1, n);
    chk("t4_arms", arms, 1);
    chk("t4_dac", DAC, 1020);

    // Step 4 over 0..8: inclusive stop.
    acc_thr = 10'd4; a_le = 13'd4096; a_gt = 13'd0;
    sweep(10'd0, 10'd8, 10'd4, -1, n);
    chk("t5_arms", arms, 3);
    chk("t5_pt2", pts[2], 8);
    chk("t5_thr", Thr50, 8);
    chk("t5_accmax", AccMax, 4096);

    // Scan block never starts: Err after SETTLE+ARM.
    mode_noscan = 1;
    sweep(10'd5, 10'd9, 10'd1, -1, n);
    mode_noscan = 0;
    chk("t6_err", Err, 1);
    chk("t6_cyc", n, 20);
    chk("t6_arms", arms, 1);
    chk("t6_found", Found, 0);

`ifdef TS_SWEEP_TIMEOUT_EN
    // Busy stuck high: watchdog fires 100 cycles into ARM+RUN.
    mode_stuck = 1;
    sweep(10'd0, 10'd3, 10'd1, -1, n);
    mode_stuck = 0;
    chk("t7_err", Err, 1);
    chk("t7_cyc", n, 116);
    chk("t7_arms", arms, 1);
`endif

    // Reset mid-RUN of point 6 after a crossing was found.
    acc_thr = 10'd3; a_le = 13'd4096; a_gt = 13'd0;
    DacStart = 10'd0; DacStop = 10'd7; DacStep = 10'd1;
    arms = 0;
    pts.delete();
    @(negedge CLK);
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    n = 0;
    while (!(arms == 7 && CMD == 8'h19 && ScanBusy === 1'b1) && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    chk("t8_reach", arms, 7);
    chk("t8_pre_found", Found, 1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("t8_cmd", CMD, 0);
    chk("t8_busy", Busy, 0);
    chk("t8_dac", DAC, 0);
    chk("t8_found", Found, 0);
    chk("t8_thr", Thr50, 0);
    chk("t8_accmax", AccMax, 0);
    chk("t8_err", Err, 0);

    sweep(10'd0, 10'd7, 10'd1, -1, n);
    chk("t9_arms", arms, 8);
    chk("t9_found", Found, 1);
    chk("t9_thr", Thr50, 4);
    chk("t9_accmax", AccMax, 4096);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
